// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential 64-bit restoring divider.
//   state_t    - FSM encoding (IDLE / EXEC / DONE)
//   ITER_LAST  - value of the iteration counter on the final iteration
//   DIV0_Q     - quotient reported for a zero divisor
//   trial_sub  - 65-bit trial subtraction used by each iteration
package div_pkg;

  localparam int DW   = 64;
  localparam int RW   = DW + 1;
  localparam int CNTW = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNTW-1:0] ITER_LAST = 7'd63;
  localparam logic [DW-1:0]   DIV0_Q    = 64'hFFFF_FFFF_FFFF_FFFF;

  // Subtract the zero-extended divisor from the shifted partial remainder.
  // Bit 64 of the result is the borrow: set means the divisor did not fit.
  function automatic logic [RW-1:0] trial_sub(input logic [RW-1:0] s,
                                              input logic [DW-1:0] d);
    return s - {1'b0, d};
  endfunction

endpackage

// File: rtl/divider64_seq_lsl65.sv
// LSL65: 65-bit logical shift left by one, with a serial bit entering at the
// LSB. Used to shift the partial remainder while pulling in the next
// dividend bit.
//   d_in  [64:0] - value to shift
//   s_in         - bit shifted in at position 0
//   d_out [64:0] - {d_in[63:0], s_in}
module LSL65 (
  input  logic [64:0] d_in,
  input  logic        s_in,
  output logic [64:0] d_out
);

  assign d_out = {d_in[63:0], s_in};

endmodule

// File: rtl/divider64_seq.sv
// divider64_seq: multi-cycle 64-bit unsigned restoring divider. One quotient
// bit per cycle, MSB first; 64 iterations after the accepting edge.
//   clk        - clock, rising edge
//   reset_n    - synchronous active-low reset
//   op_start   - start request, honoured only in IDLE
//   op_clear   - abort/clear from any state, beats op_start
//   dividend   - unsigned dividend, captured on the accepting edge
//   divisor    - unsigned divisor, captured on the accepting edge
//   op_done    - result valid (high only in DONE)
//   quotient   - registered quotient
//   remainder  - registered remainder
module divider64_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_start,
  input  logic          op_clear,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          op_done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  state_t          state;
  logic [RW-1:0]   r_q;      // partial remainder, 65 bits so the shifted-out MSB survives
  logic [DW-1:0]   q_q;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [DW-1:0]   d_q;      // captured divisor
  logic [CNTW-1:0] cnt_q;

  logic [RW-1:0]   s_shift;
  logic [RW-1:0]   t_diff;
  logic [RW-1:0]   r_nxt;
  logic [DW-1:0]   q_nxt;

  // S = {R[63:0], Q[63]}
  LSL65 u_lsl (
    .d_in  (r_q),
    .s_in  (q_q[DW-1]),
    .d_out (s_shift)
  );

  // Restoring step: keep the difference if no borrow, else keep the shift.
  always_comb begin
    t_diff = trial_sub(s_shift, d_q);
    r_nxt  = s_shift;
    q_nxt  = {q_q[DW-2:0], 1'b0};
    if (!t_diff[RW-1]) begin
      r_nxt = t_diff;
      q_nxt = {q_q[DW-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      op_done   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (op_clear) begin
      state     <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      op_done   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_start) begin
            r_q   <= '0;
            q_q   <= dividend;
            d_q   <= divisor;
            cnt_q <= '0;
            if (divisor == '0) begin
              // Divide by zero bypasses the iterations entirely.
              state     <= DONE;
              op_done   <= 1'b1;
              quotient  <= DIV0_Q;
              remainder <= dividend;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == ITER_LAST) begin
            state     <= DONE;
            op_done   <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt[DW-1:0];
          end
        end
        DONE: begin
          // Result held until op_clear or reset; op_start has no effect.
        end
        default: begin
          state   <= IDLE;
          op_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
